// File: rtl/shift_cmd_seq.sv
// Command sequencer for a 4-bit bidirectional shift register: optional parallel load, N shifts, done pulse.
// Define SHIFT_SEQ_ABORT_EN to add a synchronous abort input that ends LOAD/SHIFT early.
//
// state  | meaning
// IDLE   | ready for a command, sel=00
// LOAD   | one parallel-load cycle, sel=11
// SHIFT  | counted shift cycles, sel=01 (left) or 10 (right)
// DONE   | one-cycle completion pulse, sel=00
module shift_cmd_seq #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] cmd_data,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] in,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t           r_state;
    logic [CNT_W-1:0] r_rem;
    logic             r_dir;
    logic [1:0]       r_sel;
    logic [WIDTH-1:0] r_in;
    logic             r_busy;
    logic             r_done;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_rem_nxt;
    logic             w_dir_nxt;
    logic [1:0]       w_sel_nxt;
    logic [WIDTH-1:0] w_in_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_accept;
    logic             w_abort;

`ifdef SHIFT_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_accept  = cmd_valid && (r_state == S_IDLE);
    assign cmd_ready = (r_state == S_IDLE);
    assign sel       = r_sel;
    assign in        = r_in;
    assign busy      = r_busy;
    assign done      = r_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_dir   <= 1'b0;
            r_sel   <= 2'b00;
            r_in    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_dir   <= w_dir_nxt;
            r_sel   <= w_sel_nxt;
            r_in    <= w_in_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_dir_nxt   = r_dir;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_dir_nxt = cmd_dir;
                    w_rem_nxt = cmd_cnt;
                    if (cmd_load)
                        w_state_nxt = S_LOAD;
                    else if (cmd_cnt != '0)
                        w_state_nxt = S_SHIFT;
                    else
                        w_state_nxt = S_DONE;
                end
            end
            S_LOAD: begin
                if (w_abort || r_rem == '0) begin
                    w_state_nxt = S_DONE;
                    w_rem_nxt   = '0;
                end else begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Last shift is the one seen with remaining==1; the counter never goes below zero.
                if (w_abort || r_rem <= CNT_ONE) begin
                    w_state_nxt = S_DONE;
                    w_rem_nxt   = '0;
                end else begin
                    w_rem_nxt = r_rem - CNT_ONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_rem_nxt   = '0;
            end
        endcase
    end

    // Outputs are precomputed from the next state so sel/busy/done are registered alongside it.
    always_comb begin
        w_sel_nxt  = 2'b00;
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (w_state_nxt == S_DONE);
        w_in_nxt   = w_accept ? cmd_data : r_in;
        unique case (w_state_nxt)
            S_LOAD:  w_sel_nxt = 2'b11;
            S_SHIFT: w_sel_nxt = w_dir_nxt ? 2'b10 : 2'b01;
            default: w_sel_nxt = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_shift_cmd_seq.sv
// Bench for shift_cmd_seq: directed scenarios plus random commands checked against an expected sel-sequence model.
// Abort scenario is compiled in when SHIFT_SEQ_ABORT_EN is defined.
module tb_shift_cmd_seq;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_load;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_cnt;
    logic [WIDTH-1:0] cmd_data;
    logic [1:0]       sel;
    logic [WIDTH-1:0] in;
    logic             busy;
    logic             done;
`ifdef SHIFT_SEQ_ABORT_EN
    logic             abort;
`endif

    int total = 0;
    int bad   = 0;
    logic [WIDTH-1:0] sr;

    always #5 clk = ~clk;

    shift_cmd_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_load  (cmd_load),
        .cmd_dir   (cmd_dir),
        .cmd_cnt   (cmd_cnt),
        .cmd_data  (cmd_data),
`ifdef SHIFT_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .sel       (sel),
        .in        (in),
        .busy      (busy),
        .done      (done)
    );

    function automatic logic [8:0] obs();
        return {sel, in, busy, done, cmd_ready};
    endfunction

    function automatic logic [WIDTH-1:0] sr_step(input logic [WIDTH-1:0] q, input logic [1:0] s,
                                                 input logic [WIDTH-1:0] d);
        case (s)
            2'b01:   return {q[WIDTH-2:0], 1'b0};
            2'b10:   return {1'b0, q[WIDTH-1:1]};
            2'b11:   return d;
            default: return q;
        endcase
    endfunction

    task automatic scramble();
        cmd_load = 1'($urandom);
        cmd_dir  = 1'($urandom);
        cmd_cnt  = CNT_W'($urandom);
        cmd_data = WIDTH'($urandom);
    endtask

    // Present a command during IDLE; returns #1 after the accepting edge with valid dropped.
    task automatic issue(input logic ld, input logic dr, input logic [CNT_W-1:0] cn,
                         input logic [WIDTH-1:0] dt);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_load = ld; cmd_dir = dr; cmd_cnt = cn; cmd_data = dt;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL issue_timeout: cmd_ready=%b, required 1 within 50 cycles", cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        scramble();
    endtask

    // Walks the expected sel sequence of an accepted command, then the return to IDLE.
    task automatic check_cmd(input string nm, input logic ld, input logic dr,
                             input logic [CNT_W-1:0] cn, input logic [WIDTH-1:0] dt);
        logic [1:0] exp_sel[$];
        logic [8:0] exp;
        logic [WIDTH-1:0] exp_sr;
        exp_sel.delete();
        if (ld) exp_sel.push_back(2'b11);
        for (int i = 0; i < int'(cn); i++) exp_sel.push_back(dr ? 2'b10 : 2'b01);
        exp_sel.push_back(2'b00);
        sr = '0;
        for (int i = 0; i < exp_sel.size(); i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            exp = {exp_sel[i], dt, 1'b1, (i == exp_sel.size() - 1), 1'b0};
            total++;
            if (obs() !== exp) begin
                bad++;
                $display("FAIL %s step%0d: {sel,in,busy,done,ready}=%b required %b", nm, i, obs(), exp);
            end
            sr = sr_step(sr, sel, in);
        end
        @(posedge clk); #1;
        exp = {2'b00, dt, 1'b0, 1'b0, 1'b1};
        total++;
        if (obs() !== exp) begin
            bad++;
            $display("FAIL %s idle: {sel,in,busy,done,ready}=%b required %b", nm, obs(), exp);
        end
        if (ld) begin
            exp_sr = dr ? WIDTH'(dt >> cn) : WIDTH'(dt << cn);
            total++;
            if (sr !== exp_sr) begin
                bad++;
                $display("FAIL %s shreg: got %b required %b", nm, sr, exp_sr);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cmd_valid = 1'b1; cmd_load = 1'b1; cmd_dir = 1'b0; cmd_cnt = 3'd3; cmd_data = 4'hF;
`ifdef SHIFT_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        #12;
        total++;
        if (obs() !== {2'b00, 4'h0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_hold: {sel,in,busy,done,ready}=%b required 000000001", obs());
        end
        #8;
        rst = 1'b1;
        cmd_valid = 1'b0;
        #1;
        total++;
        if (obs() !== {2'b00, 4'h0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_release: {sel,in,busy,done,ready}=%b required 000000001", obs());
        end
        @(posedge clk); #1;
        total++;
        if (obs() !== {2'b00, 4'h0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_idle: {sel,in,busy,done,ready}=%b required 000000001", obs());
        end
    endtask

    task automatic test_load_left();
        issue(1'b1, 1'b0, 3'd2, 4'b1001);
        check_cmd("load_left", 1'b1, 1'b0, 3'd2, 4'b1001);
        total++;
        if (sr !== 4'b0100) begin
            bad++;
            $display("FAIL load_left_final: shreg=%b required 0100", sr);
        end
    endtask

    task automatic test_right();
        logic [WIDTH-1:0] d = WIDTH'($urandom);
        issue(1'b0, 1'b1, 3'd3, d);
        check_cmd("right_noload", 1'b0, 1'b1, 3'd3, d);
    endtask

    task automatic test_noop_held();
        logic dr = 1'($urandom);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_dir = 1'b0; cmd_cnt = 3'd0; cmd_data = 4'h6;
        @(posedge clk); #1;
        cmd_load = 1'b1; cmd_dir = dr; cmd_cnt = 3'd7; cmd_data = 4'b1101;
        total++;
        if (obs() !== {2'b00, 4'h6, 1'b1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL noop_done: {sel,in,busy,done,ready}=%b required 000110110", obs());
        end
        @(posedge clk); #1;
        total++;
        if (obs() !== {2'b00, 4'h6, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL held_not_accepted: {sel,in,busy,done,ready}=%b required 000110001", obs());
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        scramble();
        check_cmd("held_valid", 1'b1, dr, 3'd7, 4'b1101);
    endtask

    task automatic test_reset_mid();
        logic [WIDTH-1:0] d = WIDTH'($urandom);
        int seen = 0;
        issue(1'b0, 1'b0, 3'd5, d);
        @(posedge clk); #1;
        total++;
        if (sel !== 2'b01) begin
            bad++;
            $display("FAIL mid_second_shift: sel=%b required 01", sel);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if (obs() !== {2'b00, 4'h0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL mid_async_reset: {sel,in,busy,done,ready}=%b required 000000001", obs());
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0 || sel !== 2'b00) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL mid_no_done: %0d active cycles after reset, required 0", seen);
        end
        issue(1'b1, 1'b1, 3'd2, 4'b1010);
        check_cmd("after_reset", 1'b1, 1'b1, 3'd2, 4'b1010);
    endtask

    task automatic test_random();
        for (int k = 0; k < 25; k++) begin
            logic ld = 1'($urandom);
            logic dr = 1'($urandom);
            logic [CNT_W-1:0] cn = CNT_W'($urandom);
            logic [WIDTH-1:0] dt = WIDTH'($urandom);
            int gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) @(posedge clk);
            issue(ld, dr, cn, dt);
            check_cmd("random", ld, dr, cn, dt);
        end
    endtask

`ifdef SHIFT_SEQ_ABORT_EN
    task automatic test_abort();
        logic [WIDTH-1:0] d = WIDTH'($urandom);
        int shifts = 0;
        issue(1'b0, 1'b0, 3'd6, d);
        if (sel === 2'b01) shifts++;
        @(posedge clk); #1;
        if (sel === 2'b01) shifts++;
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        total++;
        if (shifts != 2 || obs() !== {2'b00, d, 1'b1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL abort_done: shifts=%0d obs=%b required 2 and %b", shifts, obs(),
                     {2'b00, d, 1'b1, 1'b1, 1'b0});
        end
        @(posedge clk); #1;
        total++;
        if (obs() !== {2'b00, d, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL abort_idle: obs=%b required %b", obs(), {2'b00, d, 1'b0, 1'b0, 1'b1});
        end
        @(negedge clk);
        abort = 1'b1;
        issue(1'b1, 1'b1, 3'd2, 4'b0110);
        abort = 1'b0;
        check_cmd("abort_with_valid", 1'b1, 1'b1, 3'd2, 4'b0110);
    endtask
`endif

    initial begin
        test_reset();
        test_load_left();
        test_right();
        test_noop_held();
        test_reset_mid();
`ifdef SHIFT_SEQ_ABORT_EN
        test_abort();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/shift_cmd_seq.md
Name: shift_cmd_seq

Overview:
- Command sequencer placed directly upstream of the 4-bit bidirectional shift register `bidirec`.
- Accepts one command at a time over a valid/ready handshake.
- Drives the register's `sel` and `in` cycle by cycle: an optional parallel load, then N shift cycles in one direction, then a one-cycle done pulse.
- Replaces hand-sequenced `sel` stimulus with a deterministic, counted control stage.

Parameters:
- WIDTH, 4, data width of `cmd_data` / `in`; matches the shift register width.
- CNT_W, 3, width of the shift count field; max shifts per command = 2^CNT_W - 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset; 0 = reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept; high only in IDLE.
- cmd_load  input  1  1 = perform a parallel load of `cmd_data` before shifting.
- cmd_dir  input  1  0 = shift left (sel 01), 1 = shift right (sel 10).
- cmd_cnt  input  CNT_W  number of shift cycles.
- cmd_data  input  WIDTH  parallel load value.
- sel  output  2  to shift register: 00 hold, 01 left, 10 right, 11 parallel load.
- in  output  WIDTH  to shift register data input.
- busy  output  1  command in progress (LOAD, SHIFT or DONE).
- done  output  1  one-cycle pulse at command completion.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, sel=00, in=0, busy=0, done=0, cmd_ready=1 as soon as reset releases.
  - Shift counter cleared; latched command cleared.
- Output timing:
  - `sel`, `in`, `busy` and `done` are registered.
  - `cmd_ready` = (state==IDLE), decoded from the registered state.
- Accept: on a rising edge with cmd_valid=1 and cmd_ready=1, latch dir, cnt and load; register `in`=cmd_data.
  - `in` then holds that value until the next accept.
- Transitions from IDLE on accept:
  - load=1 → LOAD; sel=11 on the next cycle.
  - load=0, cnt>0 → SHIFT; sel=01 or 10 on the next cycle.
  - load=0, cnt=0 → DONE (no-op); sel stays 00.
- LOAD (exactly 1 cycle, sel=11):
  - cnt>0 → SHIFT, with remaining=cnt.
  - cnt=0 → DONE.
- SHIFT: sel=01 (dir=0) or 10 (dir=1) for exactly cnt consecutive cycles; remaining decrements each edge.
  - remaining reaching 1 → DONE next.
- DONE (exactly 1 cycle): sel=00, done=1, busy=1, cmd_ready=0; then → IDLE.
- IDLE: sel=00, busy=0, done=0.
- Occupancy: cmd_ready stays low for (load ? 1 : 0) + cnt + 1 cycles after accept.
- cmd_valid while not ready: ignored; the command is not latched, and a requester holding valid is accepted on the first IDLE edge.
- Back-to-back: new command accepted in the IDLE cycle following DONE; minimum one IDLE cycle between commands.
- Command inputs may change freely while busy; no effect.
- Count rule: cmd_cnt = 2^CNT_W - 1 is legal. The internal counter is CNT_W bits, loaded then decremented; it never wraps below 1 in SHIFT.
- Reset mid-command: immediate return to the reset values above. No done pulse; the partial command is discarded.

Optional Feature:
- Macro SHIFT_SEQ_ABORT_EN.
- Defined: adds input port `abort` (1 bit), sampled synchronously.
  - abort=1 in LOAD or SHIFT → DONE on the next edge: sel=00, done=1, remaining shifts dropped.
  - abort in IDLE or DONE: no effect.
  - abort and cmd_valid together in IDLE: the command is accepted.
- Not defined: no `abort` port; commands always run to completion.

Test Plan:
- Reset: rst=0 for 20 ns with cmd_valid=1 → sel=00, in=0000, busy=0, done=0, cmd_ready=1 after release; no accept while rst=0.
- Load+left: load=1, dir=0, cnt=2, data=1001 → sel sequence 11, 01, 01, 00(done=1), then IDLE; in=1001 throughout; shift register ends at 0100.
- Right without load: load=0, dir=1, cnt=3 → sel 10, 10, 10, 00 with done; cmd_ready low exactly 4 cycles.
- No-op and held valid: load=0, cnt=0 → one DONE cycle, sel never leaves 00. Then hold cmd_valid high with load=1, data=1101, cnt=7 → accepted only in IDLE; 1 load + 7 shifts + done.
- Reset mid-shift: assert rst=0 during the 2nd of 5 shift cycles → sel=00 and busy=0 immediately (asynchronous); no done pulse; next command runs normally.
- (SHIFT_SEQ_ABORT_EN) abort=1 on the 2nd shift of cnt=6 → exactly 2 shift cycles seen, then sel=00, done=1, IDLE.
